// File: rtl/tf_pkg.sv
// Shared state type and lamp encodings for the north and east-west controllers.
package tf_pkg;

    typedef enum logic [2:0] {
        ALL_RED,
        GO,
        YEL,
        WALK,
        STOP
    } tf_state_t;

    localparam logic [3:0] CAR_ALL  = 4'b1111;
    localparam logic [3:0] CAR_GO   = 4'b1100;
    localparam logic [3:0] CAR_YEL  = 4'b0010;
    localparam logic [3:0] CAR_STOP = 4'b0001;

    localparam logic [1:0] WALK_ON  = 2'b10;
    localparam logic [1:0] WALK_OFF = 2'b01;
    localparam logic [1:0] WALK_ALL = 2'b11;

    function automatic logic [3:0] car_lamp(input tf_state_t s);
        case (s)
            GO:      return CAR_GO;
            YEL:     return CAR_YEL;
            default: return CAR_STOP;
        endcase
    endfunction

    function automatic logic [1:0] walk_lamp(input tf_state_t s);
        return (s == WALK) ? WALK_ON : WALK_OFF;
    endfunction

endpackage

// File: rtl/tf_phase_timer.sv
// Phase timer: counts cycles spent in the current state, clears on a state
// change, saturates at a caller-supplied limit and flags a target count.
module tf_phase_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic [CW-1:0] limit,
    input  logic [CW-1:0] target,
    output logic          done
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (count < limit) begin
            count <= count + CW'(1);
        end
    end

    assign done = (count == target);

endmodule

// File: rtl/tf_ew_ctrl.sv
// East-west traffic light controller: cycle-counted phases, clear/clear
// handshake with the north-south side, and a latched pedestrian request.
module tf_ew_ctrl
    import tf_pkg::*;
#(
    parameter int T_GO     = 5,
    parameter int T_YEL    = 2,
    parameter int T_WALK   = 4,
    parameter int T_ALLRED = 1,
    parameter int CW       = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       NS_CLEAR,
    input  logic       WALK_REQ,
    output logic [3:0] EW_CAR,
    output logic [1:0] WALK_EW,
    output logic       EW_CLEAR,
    output logic       REQ_PEND
);

    tf_state_t     state;
    tf_state_t     nxt;
    logic          lamp_test;
    logic          ns_served;
    logic          tmr_clr;
    logic          tmr_done;
    logic          enter_walk;
    logic [CW-1:0] tmr_limit;
    logic [CW-1:0] tmr_target;

    always_comb begin
        tmr_target = CW'(T_ALLRED - 1);
        case (state)
            GO:      tmr_target = CW'(T_GO - 1);
            YEL:     tmr_target = CW'(T_YEL - 1);
            WALK:    tmr_target = CW'(T_WALK - 1);
            default: tmr_target = CW'(T_ALLRED - 1);
        endcase
    end

    assign tmr_limit = (state == ALL_RED) ? CW'(T_ALLRED - 1) : '1;

    // The lamp-test pattern is not an all-stop display, so the first edge
    // after reset only raises the stop lamp; the all-red minimum counts from there.
    always_comb begin
        nxt = state;
        if (!lamp_test) begin
            case (state)
                ALL_RED: begin
                    if (!NS_CLEAR)
                        nxt = STOP;
                    else if (tmr_done)
                        nxt = GO;
                end
                GO:      if (tmr_done) nxt = YEL;
                YEL:     if (tmr_done) nxt = REQ_PEND ? WALK : STOP;
                WALK:    if (tmr_done) nxt = STOP;
                STOP:    if (ns_served && NS_CLEAR) nxt = ALL_RED;
                default: nxt = ALL_RED;
            endcase
        end
    end

    assign tmr_clr    = lamp_test || (nxt != state);
    assign enter_walk = (nxt == WALK) && (state != WALK);

    tf_phase_timer #(
        .CW(CW)
    ) u_timer (
        .clk    (CLK),
        .rst_n  (RST_N),
        .clr    (tmr_clr),
        .limit  (tmr_limit),
        .target (tmr_target),
        .done   (tmr_done)
    );

    // Lamps are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ALL_RED;
            lamp_test <= 1'b1;
            ns_served <= 1'b0;
            REQ_PEND  <= 1'b0;
            EW_CAR    <= CAR_ALL;
            WALK_EW   <= WALK_ALL;
            EW_CLEAR  <= 1'b0;
        end else begin
            state     <= nxt;
            lamp_test <= 1'b0;
            if (state == ALL_RED && nxt == STOP)
                ns_served <= 1'b1;
            else if (nxt == GO && state != GO)
                ns_served <= 1'b0;
            else if ((state == WALK || state == STOP) && !NS_CLEAR)
                ns_served <= 1'b1;
            REQ_PEND  <= WALK_REQ | (REQ_PEND & ~enter_walk);
            EW_CAR    <= car_lamp(nxt);
            WALK_EW   <= walk_lamp(nxt);
            EW_CLEAR  <= (nxt == WALK) || (nxt == STOP);
        end
    end

endmodule

// File: tb/tb_tf_ew_ctrl.sv
// Self-checking bench for tf_ew_ctrl: a cycle model pushes expected lamp words
// into a scoreboard queue, which is popped and compared after each clock edge.
module tb_tf_ew_ctrl;

    localparam int T_GO     = 5;
    localparam int T_YEL    = 2;
    localparam int T_WALK   = 4;
    localparam int T_ALLRED = 1;

    localparam int S_ALLRED = 0;
    localparam int S_GO     = 1;
    localparam int S_YEL    = 2;
    localparam int S_WALK   = 3;
    localparam int S_STOP   = 4;

    logic       CLK      = 1'b0;
    logic       RST_N    = 1'b1;
    logic       NS_CLEAR = 1'b1;
    logic       WALK_REQ = 1'b0;
    logic [3:0] EW_CAR;
    logic [1:0] WALK_EW;
    logic       EW_CLEAR;
    logic       REQ_PEND;

    int compared   = 0;
    int mismatched = 0;

    int   mState;
    int   mAge;
    bit   mLamp;
    bit   mReq;
    bit   mServed;
    logic [7:0] sb[$];
    int   goSeen;
    int   walkSeen;

    tf_ew_ctrl dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .NS_CLEAR (NS_CLEAR),
        .WALK_REQ (WALK_REQ),
        .EW_CAR   (EW_CAR),
        .WALK_EW  (WALK_EW),
        .EW_CLEAR (EW_CLEAR),
        .REQ_PEND (REQ_PEND)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
        end
    endtask

    function automatic logic [7:0] expWord();
        logic [3:0] car;
        logic [1:0] w;
        logic       c;
        case (mState)
            S_GO:    car = 4'b1100;
            S_YEL:   car = 4'b0010;
            default: car = 4'b0001;
        endcase
        w = (mState == S_WALK) ? 2'b10 : 2'b01;
        c = (mState == S_WALK) || (mState == S_STOP);
        return {car, w, c, mReq};
    endfunction

    task automatic modelReset();
        mState  = S_ALLRED;
        mAge    = 0;
        mLamp   = 1'b1;
        mReq    = 1'b0;
        mServed = 1'b0;
    endtask

    task automatic modelStep(input logic ns, input logic wr);
        int nst;
        bit wasLamp;
        bit entering;
        nst     = mState;
        wasLamp = mLamp;
        if (mLamp) begin
            mLamp = 1'b0;
        end else begin
            case (mState)
                S_ALLRED: begin
                    if (!ns) begin
                        nst     = S_STOP;
                        mServed = 1'b1;
                    end else if (mAge >= T_ALLRED - 1) begin
                        nst     = S_GO;
                        mServed = 1'b0;
                    end
                end
                S_GO:   if (mAge == T_GO - 1) nst = S_YEL;
                S_YEL:  if (mAge == T_YEL - 1) nst = mReq ? S_WALK : S_STOP;
                S_WALK: begin
                    if (mAge == T_WALK - 1) nst = S_STOP;
                    if (!ns) mServed = 1'b1;
                end
                default: begin
                    if (mServed && ns) nst = S_ALLRED;
                    if (!ns) mServed = 1'b1;
                end
            endcase
        end
        entering = (nst == S_WALK) && (mState != S_WALK);
        mReq     = wr | (mReq & !entering);
        if (wasLamp || nst != mState) mAge = 0;
        else mAge++;
        mState = nst;
    endtask

    task automatic tick(input string tag);
        logic [7:0] act;
        logic [7:0] exp;
        modelStep(NS_CLEAR, WALK_REQ);
        sb.push_back(expWord());
        @(posedge CLK);
        #1;
        act = {EW_CAR, WALK_EW, EW_CLEAR, REQ_PEND};
        exp = sb.pop_front();
        checkOutput(tag, 32'(act), 32'(exp));
        if (EW_CAR == 4'b1100) goSeen++;
        if (WALK_EW == 2'b10) walkSeen++;
    endtask

    task automatic applyStimulus(input string tag, input logic ns, input logic wr, input int n);
        NS_CLEAR = ns;
        WALK_REQ = wr;
        for (int i = 0; i < n; i++) tick(tag);
    endtask

    task automatic checkLampTest(input string tag);
        checkOutput(tag, 32'({EW_CAR, WALK_EW, EW_CLEAR, REQ_PEND}), 32'({4'b1111, 2'b11, 1'b0, 1'b0}));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST_N    = 1'b0;
        NS_CLEAR = 1'b1;
        WALK_REQ = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            checkLampTest("resetHold");
        end
        RST_N = 1'b1;
        modelReset();

        goSeen = 0;
        applyStimulus("firstAllRed", 1'b1, 1'b0, 1);
        applyStimulus("firstPass", 1'b1, 1'b0, 8);
        checkOutput("goLen", 32'(goSeen), 32'(T_GO));

        applyStimulus("stopHold", 1'b1, 1'b0, 10);
        applyStimulus("nsBusy", 1'b0, 1'b0, 6);
        applyStimulus("toAllRed", 1'b1, 1'b0, 1);
        applyStimulus("toGo", 1'b1, 1'b0, 1);

        walkSeen = 0;
        applyStimulus("reqInGo", 1'b1, 1'b1, 1);
        checkOutput("reqLatched", 32'(REQ_PEND), 32'd1);
        applyStimulus("goRest", 1'b1, 1'b0, 3);
        applyStimulus("yel", 1'b1, 1'b0, 2);
        applyStimulus("walk", 1'b1, 1'b0, 4);
        applyStimulus("walkDone", 1'b1, 1'b0, 1);
        checkOutput("walkLen", 32'(walkSeen), 32'(T_WALK));

        applyStimulus("nsBusy2", 1'b0, 1'b0, 2);
        applyStimulus("toAllRed2", 1'b1, 1'b0, 1);
        applyStimulus("toGo2", 1'b1, 1'b0, 1);
        applyStimulus("reqInGo2", 1'b1, 1'b1, 1);
        applyStimulus("goRest2", 1'b1, 1'b0, 3);
        applyStimulus("yel2", 1'b1, 1'b0, 2);
        applyStimulus("walkEntryReq", 1'b1, 1'b1, 1);
        checkOutput("walkReqHeld", 32'(REQ_PEND), 32'd1);
        applyStimulus("walk2", 1'b1, 1'b0, 3);
        applyStimulus("walkEndBusy", 1'b0, 1'b0, 1);
        applyStimulus("toAllRed3", 1'b1, 1'b0, 1);
        applyStimulus("pass3", 1'b1, 1'b0, 7);
        walkSeen = 0;
        applyStimulus("walkAgain", 1'b1, 1'b0, 1);
        checkOutput("walkReentered", 32'(walkSeen), 32'd1);
        applyStimulus("walk3", 1'b1, 1'b0, 4);

        applyStimulus("nsBusy3", 1'b0, 1'b0, 1);
        applyStimulus("toAllRed4", 1'b1, 1'b0, 1);
        goSeen = 0;
        applyStimulus("collision", 1'b0, 1'b0, 1);
        checkOutput("collisionClear", 32'(EW_CLEAR), 32'd1);
        applyStimulus("collisionStop", 1'b0, 1'b0, 3);
        checkOutput("collisionNoGo", 32'(goSeen), 32'd0);

        applyStimulus("toAllRed5", 1'b1, 1'b0, 1);
        applyStimulus("toGo5", 1'b1, 1'b0, 1);
        applyStimulus("reqInGo5", 1'b1, 1'b1, 1);
        applyStimulus("go3", 1'b1, 1'b0, 1);
        #2;
        RST_N = 1'b0;
        #1;
        checkLampTest("asyncReset");
        modelReset();
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK);
            #1;
            checkLampTest("midResetHold");
        end
        RST_N = 1'b1;
        applyStimulus("restartAllRed", 1'b1, 1'b0, 1);
        applyStimulus("restartGo", 1'b1, 1'b0, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
